// File: rtl/crc16_t.sv
// ---------------------------------------------------------------------------
// crc16_t : transmit-side DATA-phase CRC16 appender.
//
// Takes DATA packets (PID byte followed by payload) from the transfer layer and
// forwards them through a single registered output stage. It computes the USB
// CRC16 over the payload only and appends the complemented CRC, low byte first,
// as the last two beats. The CRC high byte carries tx_eop.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   tx_data_on     link_control enable; only gates the start of a new packet
//   tx_sop_en      pulse: PID beat accepted from the transfer layer
//   tx_crc_done    pulse: CRC high byte (tx_eop beat) accepted downstream
//   tx_lt_*        transfer-layer beat (sop/eop/valid/data) and its ready
//   tx_*           downstream beat (sop/eop/valid/data) and downstream ready
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. A producer holds its valid and its payload stable until the beat
// transfers. ready may be driven combinationally from the consumer's state.
// ---------------------------------------------------------------------------
module crc16_t (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_on,
  output logic       tx_sop_en,
  output logic       tx_crc_done,
  input  logic       tx_lt_sop,
  input  logic       tx_lt_eop,
  input  logic       tx_lt_valid,
  output logic       tx_lt_ready,
  input  logic [7:0] tx_lt_data,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CRC_LO = 2'd2,
    S_CRC_HI = 2'd3
  } state_e;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  // One byte of reflected CRC16, LSB of the data byte first.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in,
                                           input logic [7:0]  d);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [7:0]  data_q, data_d;

  logic        out_free;
  logic        lt_ready;
  logic        lt_accept;

  always_comb begin
    // The output register can take a new beat when empty or draining this cycle.
    out_free  = !valid_q || tx_ready;
    lt_ready  = out_free && ((state_q == S_DATA) ||
                             ((state_q == S_IDLE) && tx_data_on));
    lt_accept = tx_lt_valid && lt_ready;

    state_d = state_q;
    crc_d   = crc_q;
    valid_d = out_free ? 1'b0 : valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        // Beats without sop are consumed here and never reach the output.
        if (lt_accept && tx_lt_sop) begin
          crc_d   = CRC_INIT;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          data_d  = tx_lt_data;
          state_d = tx_lt_eop ? S_CRC_LO : S_DATA;
        end
      end
      S_DATA: begin
        // sop is ignored mid-packet; every beat is treated as payload.
        if (lt_accept) begin
          crc_d   = crc_byte(crc_q, tx_lt_data);
          valid_d = 1'b1;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          data_d  = tx_lt_data;
          if (tx_lt_eop) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (out_free) begin
          valid_d = 1'b1;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          data_d  = ~crc_q[7:0];
          state_d = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        if (out_free) begin
          valid_d = 1'b1;
          sop_d   = 1'b0;
          eop_d   = 1'b1;
          data_d  = ~crc_q[15:8];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= CRC_INIT;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
    end
  end

  assign tx_lt_ready = lt_ready;
  assign tx_valid    = valid_q;
  assign tx_sop      = sop_q;
  assign tx_eop      = eop_q;
  assign tx_data     = data_q;
  assign tx_sop_en   = lt_accept && tx_lt_sop && (state_q == S_IDLE);
  assign tx_crc_done = valid_q && tx_ready && eop_q;

endmodule

// File: tb/tb_crc16_t.sv
// ---------------------------------------------------------------------------
// tb_crc16_t : self-checking bench for crc16_t.
// ---------------------------------------------------------------------------
module tb_crc16_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_data_on = 1'b1;
  logic       tx_sop_en;
  logic       tx_crc_done;
  logic       tx_lt_sop = 1'b0;
  logic       tx_lt_eop = 1'b0;
  logic       tx_lt_valid = 1'b0;
  logic       tx_lt_ready;
  logic [7:0] tx_lt_data = 8'h00;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;

  crc16_t dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data_on  (tx_data_on),
    .tx_sop_en   (tx_sop_en),
    .tx_crc_done (tx_crc_done),
    .tx_lt_sop   (tx_lt_sop),
    .tx_lt_eop   (tx_lt_eop),
    .tx_lt_valid (tx_lt_valid),
    .tx_lt_ready (tx_lt_ready),
    .tx_lt_data  (tx_lt_data),
    .tx_sop      (tx_sop),
    .tx_eop      (tx_eop),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data)
  );

  // ---------------- clock / cycle counter / downstream ready ----------------
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random ready

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
    end
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [9:0] exp_q[$];          // {sop, eop, data}
  int         crc_done_cnt = 0;
  int         sop_en_cnt = 0;
  int         sop_cyc_q[$];
  logic [7:0] payload [0:63];

  // ---------------- downstream monitor ----------------
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out = '0;
  logic [9:0]  exp_beat;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        n_checks++;
        if ({tx_valid, tx_sop, tx_eop, tx_data} !== prev_out) begin
          n_fail++;
          $display("FAIL stall_hold: got %h expected %h", {tx_valid, tx_sop, tx_eop, tx_data}, prev_out);
        end
      end
      if (tx_valid && !tx_ready) begin
        n_checks++;
        if (tx_lt_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_lt_ready: got %b expected 0", tx_lt_ready);
        end
      end
      if (tx_sop_en) begin
        sop_en_cnt++;
        sop_cyc_q.push_back(cyc);
      end
      if (tx_valid && tx_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got sop=%b eop=%b data=%h expected no beat", tx_sop, tx_eop, tx_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({tx_sop, tx_eop, tx_data} !== exp_beat || tx_crc_done !== exp_beat[8]) begin
            n_fail++;
            $display("FAIL beat: got sop=%b eop=%b data=%h crc_done=%b expected sop=%b eop=%b data=%h crc_done=%b",
                     tx_sop, tx_eop, tx_data, tx_crc_done, exp_beat[9], exp_beat[8], exp_beat[7:0], exp_beat[8]);
          end
        end
        if (tx_crc_done) crc_done_cnt++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_out   = {tx_valid, tx_sop, tx_eop, tx_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Expected downstream stream for a packet: PID, payload, ~CRC low, ~CRC high.
  // CRC is computed over the payload as a serial bit stream, LSB of each byte first.
  task automatic model_pkt(input logic [7:0] pid, input int n);
    logic [15:0] crc;
    bit          bq[$];
    exp_q.push_back({1'b1, 1'b0, pid});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({2'b00, payload[i]});
      for (int b = 0; b < 8; b++) bq.push_back(payload[i][b]);
    end
    crc = 16'hFFFF;
    foreach (bq[k]) begin
      if (crc[0] ^ bq[k]) crc = (crc >> 1) ^ 16'hA001;
      else                crc = crc >> 1;
    end
    crc = ~crc;
    exp_q.push_back({2'b00, crc[7:0]});
    exp_q.push_back({2'b01, crc[15:8]});
  endtask

  // Known-answer stream for PID 0xC3 + "123456789".
  task automatic push_check_vector_exp();
    exp_q.push_back({2'b10, 8'hC3});
    for (int i = 0; i < 9; i++) exp_q.push_back({2'b00, 8'h31 + 8'(i)});
    exp_q.push_back({2'b00, 8'hC8});
    exp_q.push_back({2'b01, 8'hB4});
  endtask

  task automatic load_check_payload();
    for (int i = 0; i < 9; i++) payload[i] = 8'h31 + 8'(i);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic sop, input logic eop, input logic [7:0] d);
    int t;
    t = 0;
    tx_lt_valid = 1'b1;
    tx_lt_sop   = sop;
    tx_lt_eop   = eop;
    tx_lt_data  = d;
    forever begin
      @(negedge clk);
      if (tx_lt_ready) break;
      t++;
      if (t > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: tx_lt_ready stayed 0 for %0d cycles, expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    tx_lt_valid = 1'b0;
    tx_lt_sop   = 1'b0;
    tx_lt_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] pid, input int n);
    if (n == 0) begin
      drive_beat(1'b1, 1'b1, pid);
    end else begin
      drive_beat(1'b1, 1'b0, pid);
      for (int i = 0; i < n; i++) drive_beat(1'b0, (i == n - 1), payload[i]);
    end
  endtask

  task automatic wait_drain(output int left);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    left = exp_q.size();
  endtask

  task automatic clear_counts();
    crc_done_cnt = 0;
    sop_en_cnt   = 0;
    sop_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tx_data_on = 1'b1;
    #3;
    n_checks++;
    if ({tx_valid, tx_sop, tx_eop, tx_data, tx_crc_done, tx_sop_en} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {tx_valid, tx_sop, tx_eop, tx_data, tx_crc_done, tx_sop_en});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_lt_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_on: got lt_ready=%b valid=%b expected 1 0", tx_lt_ready, tx_valid);
    end
    tx_data_on = 1'b0;
    #1;
    n_checks++;
    if (tx_lt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_off: got %b expected 0", tx_lt_ready);
    end
    tx_data_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_check_vector();
    int left;
    ready_mode = 0;
    clear_counts();
    load_check_payload();
    push_check_vector_exp();
    send_pkt(8'hC3, 9);
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL check_vector_drain: got %0d outstanding expected 0", left);
    end
    n_checks++;
    if (crc_done_cnt != 1 || sop_en_cnt != 1) begin
      n_fail++;
      $display("FAIL check_vector_pulses: got crc_done=%0d sop_en=%0d expected 1 1", crc_done_cnt, sop_en_cnt);
    end
  endtask

  task automatic test_zero_length();
    int left;
    ready_mode = 0;
    clear_counts();
    exp_q.push_back({2'b10, 8'h4B});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'h00});
    send_pkt(8'h4B, 0);
    wait_drain(left);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL zlp_drain: got %0d outstanding expected 0", left);
    end
    n_checks++;
    if (crc_done_cnt != 1 || sop_en_cnt != 1) begin
      n_fail++;
      $display("FAIL zlp_pulses: got crc_done=%0d sop_en=%0d expected 1 1", crc_done_cnt, sop_en_cnt);
    end
  endtask

  task automatic test_backpressure();
    int left;
    ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      clear_counts();
      load_check_payload();
      push_check_vector_exp();
      send_pkt(8'hC3, 9);
      wait_drain(left);
      n_checks++;
      if (left != 0 || crc_done_cnt != 1) begin
        n_fail++;
        $display("FAIL backpressure_pkt: got outstanding=%0d crc_done=%0d expected 0 1", left, crc_done_cnt);
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    int left;
    ready_mode = 0;
    clear_counts();
    for (int i = 0; i < 5; i++) payload[i] = 8'($urandom);
    model_pkt(8'hC3, 5);
    send_pkt(8'hC3, 5);
    for (int i = 0; i < 3; i++) payload[i] = 8'($urandom);
    model_pkt(8'h4B, 3);
    send_pkt(8'h4B, 3);
    wait_drain(left);
    n_checks++;
    if (left != 0 || crc_done_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_pkts: got outstanding=%0d crc_done=%0d expected 0 2", left, crc_done_cnt);
    end
    n_checks++;
    if (sop_cyc_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_sop_count: got %0d expected 2", sop_cyc_q.size());
    end else if (sop_cyc_q[1] - sop_cyc_q[0] != 8) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles expected 8", sop_cyc_q[1] - sop_cyc_q[0]);
    end
  endtask

  task automatic test_gating();
    int left;
    int bad;
    ready_mode = 0;
    clear_counts();
    tx_data_on  = 1'b0;
    tx_lt_valid = 1'b1;
    tx_lt_sop   = 1'b1;
    tx_lt_data  = 8'hC3;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx_lt_ready !== 1'b0 || tx_valid !== 1'b0 || tx_sop_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gating_idle: got %0d cycles with activity expected 0", bad);
    end
    @(posedge clk);
    #1;
    tx_lt_valid = 1'b0;
    tx_lt_sop   = 1'b0;
    tx_data_on  = 1'b1;
    load_check_payload();
    push_check_vector_exp();
    drive_beat(1'b1, 1'b0, 8'hC3);
    tx_data_on = 1'b0;
    for (int i = 0; i < 9; i++) drive_beat(1'b0, (i == 8), payload[i]);
    wait_drain(left);
    n_checks++;
    if (left != 0 || crc_done_cnt != 1) begin
      n_fail++;
      $display("FAIL gating_drop: got outstanding=%0d crc_done=%0d expected 0 1", left, crc_done_cnt);
    end
    tx_data_on = 1'b1;
  endtask

  task automatic test_stray();
    int left;
    int bad;
    ready_mode = 0;
    clear_counts();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b0, (i == 4), 8'($urandom));
      if (tx_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || sop_en_cnt != 0) begin
      n_fail++;
      $display("FAIL stray_dropped: got valid_count=%0d sop_en=%0d expected 0 0", bad, sop_en_cnt);
    end
    load_check_payload();
    push_check_vector_exp();
    send_pkt(8'hC3, 9);
    wait_drain(left);
    n_checks++;
    if (left != 0 || crc_done_cnt != 1) begin
      n_fail++;
      $display("FAIL stray_then_pkt: got outstanding=%0d crc_done=%0d expected 0 1", left, crc_done_cnt);
    end
  endtask

  task automatic test_async_reset();
    int left;
    ready_mode = 0;
    load_check_payload();
    push_check_vector_exp();
    drive_beat(1'b1, 1'b0, 8'hC3);
    for (int i = 0; i < 3; i++) drive_beat(1'b0, 1'b0, payload[i]);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid, tx_sop, tx_eop, tx_data, tx_crc_done, tx_sop_en} !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h expected 0", {tx_valid, tx_sop, tx_eop, tx_data, tx_crc_done, tx_sop_en});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_counts();
    push_check_vector_exp();
    send_pkt(8'hC3, 9);
    wait_drain(left);
    n_checks++;
    if (left != 0 || crc_done_cnt != 1) begin
      n_fail++;
      $display("FAIL async_reset_next_pkt: got outstanding=%0d crc_done=%0d expected 0 1", left, crc_done_cnt);
    end
  endtask

  task automatic test_random();
    int left;
    int n;
    logic [7:0] pid;
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      ready_mode = $urandom_range(0, 1);
      n   = $urandom_range(0, 20);
      pid = 8'($urandom);
      for (int i = 0; i < n; i++) payload[i] = 8'($urandom);
      model_pkt(pid, n);
      send_pkt(pid, n);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain(left);
    ready_mode = 0;
    n_checks++;
    if (left != 0 || crc_done_cnt != 10 || sop_en_cnt != 10) begin
      n_fail++;
      $display("FAIL random_pkts: got outstanding=%0d crc_done=%0d sop_en=%0d expected 0 10 10",
               left, crc_done_cnt, sop_en_cnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_check_vector();
    test_zero_length();
    test_backpressure();
    test_back_to_back();
    test_gating();
    test_stray();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
